mulxx_seq: RTL and testbench

Sequential, parametrised successor to the combinational `mulxx` multiplier for the 18-bit processor datapath. It computes `(r0 * r1) >>> shift` over an iterative shift-add core that retires `BITS_PER_CYCLE` multiplier bits per clock, with a start/busy/done handshake. This trades latency for area so that `mulxx` can be replaced in area-constrained builds. It sits beside the ALU, and the processor control stalls on `busy`.

---
 rtl/asm18_pkg.sv | 19 +
 rtl/mulxx_seq_step.sv | 23 ++
 rtl/mulxx_seq.sv | 136 +++++++++++++
 tb/tb_mulxx_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asm18_pkg.sv
// Shared types and helpers for the asm18 datapath.
// Provides the mulxx_seq FSM state type, shift-width and legality helpers.
package asm18_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } mulxx_state_t;

  function automatic int mulxx_shift_w(input int word_size);
    return $clog2(word_size + 1);
  endfunction

  function automatic bit mulxx_bpc_ok(input int w, input int b);
    return ((b == 1) || (b == 2) || (b == 3) || (b == 6)) && ((w % b) == 0);
  endfunction

endpackage

// File: rtl/mulxx_seq_step.sv
// One radix-2^B shift-add step: acc_next = acc + mcand * ybits.
// Ports: acc, mcand (pre-shifted magnitude), ybits (B multiplier bits), acc_next.
module mulxx_seq_step #(
  parameter int W2 = 36,
  parameter int B  = 1
) (
  input  logic [W2-1:0] acc,
  input  logic [W2-1:0] mcand,
  input  logic [B-1:0]  ybits,
  output logic [W2-1:0] acc_next
);

  logic [W2-1:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < B; i++) begin
      if (ybits[i]) pp = pp + (mcand << i);
    end
    acc_next = acc + pp;
  end

endmodule

// File: rtl/mulxx_seq.sv
// Iterative (r0*r1)>>>shift multiplier with start/busy/done handshake.
// Ports: clock, reset_n, start, r0, r1, shift, signx, signy -> busy, done, res.
// Optional MULXX_SEQ_ROUND_EN: round half up before the final shift.
module mulxx_seq
  import asm18_pkg::*;
#(
  parameter int WORD_SIZE      = 18,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHIFT_W        = mulxx_shift_w(WORD_SIZE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] r0,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 signx,
  input  logic                 signy,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] res
);

  localparam int W  = WORD_SIZE;
  localparam int B  = BITS_PER_CYCLE;
  localparam int W2 = 2 * W;
  localparam int N  = W / B;
  localparam int CW = $clog2(N + 1);

  if (!mulxx_bpc_ok(W, B)) begin : g_bad_bpc
    $error("mulxx_seq: illegal BITS_PER_CYCLE");
  end

  mulxx_state_t       state, state_nx;
  logic [CW-1:0]      cnt;
  logic [W2-1:0]      acc, acc_nx, mcand;
  logic [W-1:0]       ymul;
  logic               neg, sgn;
  logic [SHIFT_W-1:0] sh;

  logic               x_neg, y_neg;
  logic [W-1:0]       xmag, ymag;
  logic [SHIFT_W-1:0] sh_cl;

  assign x_neg = signx & r0[W-1];
  assign y_neg = signy & r1[W-1];
  assign xmag  = x_neg ? -r0 : r0;
  assign ymag  = y_neg ? -r1 : r1;
  assign sh_cl = (shift > SHIFT_W'(W)) ? SHIFT_W'(W) : shift;

  mulxx_seq_step #(
    .W2(W2),
    .B (B)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .ybits   (ymul[B-1:0]),
    .acc_next(acc_nx)
  );

  // Sign restore on the magnitude, then a 2W+1 bit arithmetic shift.
  // The extra top bit carries the sign (zero when unsigned), so one
  // >>> serves both the floor and the logical case.
  logic [W2-1:0]        p_mag;
  logic [W2:0]          p_ext, p_rnd;
  logic signed [W2:0]   p_s;
  logic [W2:0]          p_sh;

  always_comb begin
    p_mag = neg ? -acc : acc;
    p_ext = {sgn & p_mag[W2-1], p_mag};
`ifdef MULXX_SEQ_ROUND_EN
    p_rnd = p_ext;
    if (sh != '0) p_rnd = p_ext + ((W2+1)'(1) << (sh - 1'b1));
`else
    p_rnd = p_ext;
`endif
    p_s  = p_rnd;
    p_sh = p_s >>> sh;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      ymul  <= '0;
      neg   <= 1'b0;
      sgn   <= 1'b0;
      sh    <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{W{1'b0}}, xmag};
            ymul  <= ymag;
            neg   <= x_neg ^ y_neg;
            sgn   <= signx | signy;
            sh    <= sh_cl;
            acc   <= '0;
            cnt   <= CW'(N);
          end
        end
        RUN: begin
          acc   <= acc_nx;
          mcand <= mcand << B;
          ymul  <= ymul >> B;
          cnt   <= cnt - 1'b1;
        end
        FIN:     res <= p_sh[W-1:0];
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mulxx_seq.sv
// Self-checking bench for mulxx_seq across BITS_PER_CYCLE 1, 2, 3, 6.
// Directed table, handshake corner sequences and a random sweep.
module tb_mulxx_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] r0 = '0;
  logic [17:0] r1 = '0;
  logic [4:0]  sh = '0;
  logic        sx = 1'b0;
  logic        sy = 1'b0;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [17:0] res_v [4];

  int nv [4] = '{18, 9, 6, 3};
  int bv [4] = '{1, 2, 3, 6};
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mulxx_seq #(.WORD_SIZE(18), .BITS_PER_CYCLE(1)) u1 (
    .clock(clk), .reset_n(rst_n), .start(start), .r0(r0), .r1(r1),
    .shift(sh), .signx(sx), .signy(sy),
    .busy(busy_v[0]), .done(done_v[0]), .res(res_v[0]));
  mulxx_seq #(.WORD_SIZE(18), .BITS_PER_CYCLE(2)) u2 (
    .clock(clk), .reset_n(rst_n), .start(start), .r0(r0), .r1(r1),
    .shift(sh), .signx(sx), .signy(sy),
    .busy(busy_v[1]), .done(done_v[1]), .res(res_v[1]));
  mulxx_seq #(.WORD_SIZE(18), .BITS_PER_CYCLE(3)) u3 (
    .clock(clk), .reset_n(rst_n), .start(start), .r0(r0), .r1(r1),
    .shift(sh), .signx(sx), .signy(sy),
    .busy(busy_v[2]), .done(done_v[2]), .res(res_v[2]));
  mulxx_seq #(.WORD_SIZE(18), .BITS_PER_CYCLE(6)) u6 (
    .clock(clk), .reset_n(rst_n), .start(start), .r0(r0), .r1(r1),
    .shift(sh), .signx(sx), .signy(sy),
    .busy(busy_v[3]), .done(done_v[3]), .res(res_v[3]));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] ref_m(input logic [17:0] a,
      input logic [17:0] b, input logic [4:0] s,
      input logic ssx, input logic ssy);
    logic signed [39:0] x, y, p;
    int k;
    x = ssx ? {{22{a[17]}}, a} : {22'b0, a};
    y = ssy ? {{22{b[17]}}, b} : {22'b0, b};
    p = x * y;
    k = (s > 5'd18) ? 18 : int'(s);
`ifdef MULXX_SEQ_ROUND_EN
    if (k > 0) p = p + (40'sd1 <<< (k - 1));
`endif
    p = p >>> k;
    return p[17:0];
  endfunction

  task automatic run_op(input logic [17:0] a, input logic [17:0] b,
      input logic [4:0] s, input logic ssx, input logic ssy,
      input logic [17:0] exp, input string nm, input int mid);
    int lat [4];
    logic [17:0] got [4];
    int bcnt;
    logic ovl;
    bit all;
    @(negedge clk);
    r0 = a; r1 = b; sh = s; sx = ssx; sy = ssy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lat[k] = -1;
      got[k] = 'x;
    end
    bcnt = 0;
    ovl = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == mid) begin
        start = 1'b1; r0 = 18'h1234; r1 = 18'h0777; sh = 5'd0;
      end
      if (c == mid + 1) start = 1'b0;
      if (busy_v[0]) bcnt++;
      all = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (busy_v[k] && done_v[k]) ovl = 1'b1;
        if (done_v[k] && lat[k] < 0) begin
          lat[k] = c;
          got[k] = res_v[k];
        end
        if (lat[k] < 0) all = 1'b0;
      end
      if (all) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s B%0d res", nm, bv[k]), 32'(got[k]), 32'(exp));
      chk($sformatf("%s B%0d latency", nm, bv[k]), lat[k], nv[k] + 1);
    end
    chk($sformatf("%s busy cycles", nm), bcnt, 19);
    chk($sformatf("%s busy&done", nm), 32'(ovl), 0);
    @(posedge clk); #1;
    chk($sformatf("%s idle after done", nm), 32'(busy_v[0]), 0);
    chk($sformatf("%s res held", nm), 32'(res_v[0]), 32'(exp));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (busy_v != 4'b0 && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain idle", 32'(busy_v), 0);
  endtask

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [4:0]  s;
    logic        ssx;
    logic        ssy;
    logic [17:0] exp;
    string       nm;
  } vec_t;

  vec_t vt [12];

  initial begin
    int d1, d2;
    logic sawd;
    logic [17:0] ra, rb;
    logic [4:0] rs;
    logic rx, ry;

    vt[0]  = '{18'd2, 18'd3, 5'd0, 1'b0, 1'b0, 18'd6, "u2x3"};
    vt[1]  = '{18'h3FFFF, 18'h3FFFF, 5'd18, 1'b0, 1'b0, 18'h3FFFE, "ufull"};
    vt[2]  = '{18'd47273, 18'd56782, 5'd17, 1'b0, 1'b0, 18'h04FFF, "umid"};
`ifdef MULXX_SEQ_ROUND_EN
    vt[3]  = '{18'h30001, 18'h0FFFF, 5'd16, 1'b1, 1'b1, 18'h30002, "sfloor"};
`else
    vt[3]  = '{18'h30001, 18'h0FFFF, 5'd16, 1'b1, 1'b1, 18'h30001, "sfloor"};
`endif
    vt[4]  = '{18'h3FFFF, 18'h3FFFF, 5'd0, 1'b1, 1'b1, 18'd1, "sm1m1"};
    vt[5]  = '{18'h3FFFE, 18'd3, 5'd0, 1'b1, 1'b0, 18'h3FFFA, "smix6"};
`ifdef MULXX_SEQ_ROUND_EN
    vt[6]  = '{18'd3, 18'd1, 5'd1, 1'b0, 1'b0, 18'd2, "rnd_p"};
    vt[7]  = '{18'h3FFFD, 18'd1, 5'd1, 1'b1, 1'b0, 18'h3FFFF, "rnd_n"};
`else
    vt[6]  = '{18'd3, 18'd1, 5'd1, 1'b0, 1'b0, 18'd1, "rnd_p"};
    vt[7]  = '{18'h3FFFD, 18'd1, 5'd1, 1'b1, 1'b0, 18'h3FFFE, "rnd_n"};
`endif
    vt[8]  = '{18'h3FFFF, 18'h3FFFF, 5'd25, 1'b0, 1'b0, 18'h3FFFE, "clamp"};
    vt[9]  = '{18'h3FFFF, 18'h3FFFF, 5'd0, 1'b0, 1'b1, 18'd1, "wrap"};
    vt[10] = '{18'h20000, 18'h20000, 5'd18, 1'b1, 1'b1, 18'h10000, "minmin"};
    vt[11] = '{18'd5, 18'd7, 5'd18, 1'b0, 1'b0, 18'd0, "small"};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset B%0d busy", bv[k]), 32'(busy_v[k]), 0);
      chk($sformatf("reset B%0d done", bv[k]), 32'(done_v[k]), 0);
      chk($sformatf("reset B%0d res", bv[k]), 32'(res_v[k]), 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].ssx, vt[i].ssy,
             vt[i].exp, vt[i].nm, -10);

    run_op(18'd100, 18'd200, 5'd2, 1'b0, 1'b0, 18'd5000, "midstart", 2);
    drain();

    @(negedge clk);
    r0 = 18'd2; r1 = 18'd3; sh = 5'd0; sx = 1'b0; sy = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 60; c++) begin
      if (d1 >= 0 && c == d1 + 1)
        chk("b2b busy after done", 32'(busy_v[0]), 1);
      if (done_v[0]) begin
        if (d1 < 0) begin
          d1 = c;
          chk("b2b busy in done", 32'(busy_v[0]), 0);
          chk("b2b res1", 32'(res_v[0]), 6);
        end else begin
          d2 = c;
          chk("b2b res2", 32'(res_v[0]), 6);
          break;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b first done", d1, 19);
    chk("b2b second done", d2, 39);
    drain();

    @(negedge clk);
    r0 = 18'd5; r1 = 18'd7; sh = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst busy", 32'(busy_v[0]), 0);
    chk("rst res", 32'(res_v[0]), 0);
    chk("rst done", 32'(done_v[0]), 0);
    rst_n = 1'b1;
    sawd = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_v != 4'b0 || busy_v != 4'b0) sawd = 1'b1;
    end
    chk("rst no done", 32'(sawd), 0);

    for (int i = 0; i < 120; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      rs = 5'($urandom_range(0, 20));
      rx = 1'($urandom);
      ry = 1'($urandom);
      run_op(ra, rb, rs, rx, ry, ref_m(ra, rb, rs, rx, ry),
             $sformatf("rnd%0d", i), -10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
